// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- buffered 8-bit UART transmitter
//
// Bytes presented with in_valid are queued in a small FIFO and sent
// on txd as 8N1 frames (start bit, bits 0..7 LSB first, stop bit). Frames
// queued back to back are sent with no idle time between them. Every bit,
// including start and stop, lasts 2*CLK_PER_HALF_BIT clocks.
//
// Optional feature (compile-time macro):
//   UART_TX_PARITY_EN : when defined, an even-parity bit (XOR of the eight
//                       data bits) is sent between bit 7 and the stop bit,
//                       giving an 11-bit frame. Undefined: 10-bit frame.
//
// Parameters:
//   CLK_PER_HALF_BIT : clocks per half bit period (bit = 2x this)
//   FIFO_DEPTH       : transmit FIFO entries, power of two, >= 2
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset; aborts any frame, empties FIFO
//   sdata    in   [7:0] byte to transmit
//   in_valid in   sdata valid this cycle
//   in_ready out  FIFO not full (registered)
//   txd      out  serial line, idle high (registered)
//   tx_busy  out  frame on the line or bytes still queued (registered)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sdata,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       txd,
    output logic       tx_busy
);

    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int CW       = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CLKS - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    state_t          r_state;
    logic [CW-1:0]   r_bit_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_txd;
    logic            r_busy;
    logic            r_in_ready;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [7:0]      r_mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic            r_parity;
`endif

    // ---------------------------------------------------------------
    // Combinational signals
    // ---------------------------------------------------------------
    state_t          w_state_next;
    logic [CW-1:0]   w_cnt_next;
    logic [2:0]      w_idx_next;
    logic [7:0]      w_shift_next;
    logic            w_txd_next;
    logic            w_pop;
    logic            w_push;
    logic            w_bit_done;
    logic            w_fifo_empty;
    logic [7:0]      w_head;
    logic [AW:0]     w_count_next;

    // in_ready is a register, so the push qualifier has no path back to it.
    assign w_push       = in_valid && r_in_ready;
    assign w_bit_done   = (r_bit_cnt == BIT_LAST);
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_mem[r_rd_ptr];

    // ---------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_bit_cnt + 1'b1;
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_txd_next   = r_txd;
        w_pop        = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                    w_txd_next   = 1'b0;
                end
            end

            START: begin
                if (w_bit_done) begin
                    w_state_next = DATA;
                    w_cnt_next   = '0;
                    w_idx_next   = 3'd0;
                    w_txd_next   = r_shift[0];
                    w_shift_next = {1'b0, r_shift[7:1]};
                end
            end

            DATA: begin
                if (w_bit_done) begin
                    w_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
                        w_txd_next   = r_parity;
`else
                        w_state_next = STOP;
                        w_txd_next   = 1'b1;
`endif
                    end else begin
                        w_idx_next   = r_bit_idx + 1'b1;
                        w_txd_next   = r_shift[0];
                        w_shift_next = {1'b0, r_shift[7:1]};
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_state_next = STOP;
                    w_cnt_next   = '0;
                    w_txd_next   = 1'b1;
                end
            end
`endif

            STOP: begin
                if (w_bit_done) begin
                    w_cnt_next = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                        w_txd_next   = 1'b0;
                    end else begin
                        w_state_next = IDLE;
                        w_txd_next   = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
                w_txd_next   = 1'b1;
            end
        endcase

        if (w_pop) begin
            w_shift_next = w_head;
        end
    end

    // FIFO occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // ---------------------------------------------------------------
    // State and FIFO control registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_cnt_next;
            r_bit_idx  <= w_idx_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
            r_busy     <= (w_state_next != IDLE) || (w_count_next != '0);
            r_in_ready <= (w_count_next != DEPTH_C);
            r_count    <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured with the byte so it is ready when bit 7 ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    // FIFO storage needs no reset: validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sdata;
        end
    end

    assign in_ready = r_in_ready;
    assign txd      = r_txd;
    assign tx_busy  = r_busy;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_PER_HALF_BIT, default 5208: clocks per half bit; one bit period is 2*CLK_PER_HALF_BIT clocks.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries, a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port sdata, input, 8: byte to transmit.
REQ-006 SHALL have port in_valid, input, 1: sdata is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: FIFO can accept a byte; registered, driven by !full.
REQ-008 SHALL have port txd, output, 1: serial line, idle high, registered.
REQ-009 SHALL have port tx_busy, output, 1: high while a frame is on the line or the FIFO is non-empty.

Function
REQ-010 SHALL push sdata into the FIFO on any edge where in_valid && in_ready; no byte is accepted while in_valid is low.
REQ-011 SHALL keep in_ready free of any combinational path from in_valid.
REQ-012 SHALL leave occupancy unchanged on a simultaneous push and pop, and write no entry while full.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, and PARITY when enabled.
REQ-014 SHALL, in IDLE with the FIFO non-empty, pop the head entry, load the shift register, drive txd=0 and enter START, all on the same edge.
REQ-015 SHALL, for a push into an empty FIFO while IDLE at edge N, drive txd low from edge N+1.
REQ-016 SHALL hold each of START, each data bit, PARITY and STOP for exactly 2*CLK_PER_HALF_BIT clocks, timed by a bit counter that is cleared on each state entry.
REQ-017 SHALL send data bits LSB first (bit 0 through bit 7) in DATA, tracking the index with a 3-bit counter.
REQ-018 SHALL drive txd=1 in STOP.
REQ-019 SHALL, at the end of STOP, start the next frame on the immediately following edge if the FIFO is non-empty (zero idle gap), else enter IDLE.
REQ-020 SHALL set tx_busy = (state != IDLE) || (count != 0), registered.
REQ-021 SHALL accept FIFO pushes during a transmission without disturbing the frame in progress.
REQ-022 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH and use a count of width log2(FIFO_DEPTH)+1.

Reset
REQ-023 SHALL on rst: txd=1, in_ready=1, tx_busy=0, state=IDLE, FIFO emptied, and all counters cleared.
REQ-024 SHALL, on rst asserted mid-frame, abort the frame immediately, discard all FIFO contents, and return txd high with no partial-frame completion after release.

Configuration
REQ-025 SHALL, with macro UART_TX_PARITY_EN defined, insert one PARITY bit between bit 7 and STOP carrying even parity (XOR of the 8 data bits), for an 11-bit frame.
REQ-026 SHALL, without UART_TX_PARITY_EN, omit the PARITY state entirely, for a 10-bit frame.

Verification (CLK_PER_HALF_BIT=4, so bit period = 8 clocks)
REQ-027 SHALL cover: push 0x55 while idle -> txd low 1 cycle later, then 0,1,0,1,0,1,0,1,0,1 with 8 clocks each; 80 clocks total, then tx_busy=0.
REQ-028 SHALL cover: push 0xA3 then 0x0F back-to-back -> second start bit directly follows the first stop bit with no idle clock; LSB-first patterns correct.
REQ-029 SHALL cover: 6 pushes with in_valid held high and FIFO_DEPTH=4 -> in_ready drops once full, no byte lost or duplicated, and 6 frames are sent in order.
REQ-030 SHALL cover: rst asserted at clock 37 of a frame -> txd=1 and in_ready=1 immediately, tx_busy=0, and no further transitions on txd.
REQ-031 SHALL cover: UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1 and 88-clock frame; send 0x03 -> parity bit=0.
REQ-032 SHALL cover: in_valid pulsed while full -> pulse ignored; occupancy stays 4.
